// File: rtl/wb_arb_pkg.sv
// Shared types for the dual-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Saturating transfer watchdog; raises a one-cycle timeout when a granted
// transfer has gone TIMEOUT_CYCLES cycles without an acknowledge.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    if (TIMEOUT_CYCLES == 0) begin : g_bypass
        assign timeout = 1'b0;
    end else begin : g_count
        localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

        logic [CntW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr) begin
                cnt_d = '0;
            end else if (en && (cnt_q != {CntW{1'b1}})) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign timeout = en && (cnt_q == Limit);
    end

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone-classic slave between the
// instruction-fetch (I) and load/store (D) masters, with a transfer watchdog.
module wb_dual_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cyc,
    input  logic                  i_stb,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data_out,
    output logic [DATA_WIDTH-1:0] i_data_in,
    output logic                  i_ack,
    output logic                  i_err,
    input  logic                  d_cyc,
    input  logic                  d_stb,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_data_out,
    output logic [DATA_WIDTH-1:0] d_data_in,
    output logic                  d_ack,
    output logic                  d_err,
    output logic                  s_cyc,
    output logic                  s_stb,
    output logic                  s_we,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_data_out,
    input  logic [DATA_WIDTH-1:0] s_data_in,
    input  logic                  s_ack
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       i_req, d_req;
    logic       wd_clr, wd_en, timeout;

    assign i_req = i_cyc & i_stb;
    assign d_req = d_cyc & d_stb;

    // Every grant passes through IDLE, so clearing there restarts the count per transfer.
    assign wd_clr = (state_q == IDLE);
    assign wd_en  = (state_q != IDLE) && !s_ack;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .timeout(timeout)
    );

    assign i_data_in = s_data_in;
    assign d_data_in = s_data_in;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        s_cyc      = 1'b0;
        s_stb      = 1'b0;
        s_we       = 1'b0;
        s_addr     = '0;
        s_data_out = '0;
        i_ack      = 1'b0;
        i_err      = 1'b0;
        d_ack      = 1'b0;
        d_err      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    state_d = (last_q == PORT_I) ? GRANT_D : GRANT_I;
                end else if (i_req) begin
                    state_d = GRANT_I;
                end else if (d_req) begin
                    state_d = GRANT_D;
                end
            end
            GRANT_I: begin
                s_cyc      = i_cyc;
                s_stb      = i_stb;
                s_we       = i_we;
                s_addr     = i_addr;
                s_data_out = i_data_out;
                // An abort must not advance last_grant, so it is checked first.
                if (!i_cyc) begin
                    state_d = IDLE;
                end else if (s_ack) begin
                    i_ack   = 1'b1;
                    state_d = IDLE;
                    last_d  = PORT_I;
                end else if (timeout) begin
                    i_err   = 1'b1;
                    state_d = IDLE;
                    last_d  = PORT_I;
                end
            end
            GRANT_D: begin
                s_cyc      = d_cyc;
                s_stb      = d_stb;
                s_we       = d_we;
                s_addr     = d_addr;
                s_data_out = d_data_out;
                if (!d_cyc) begin
                    state_d = IDLE;
                end else if (s_ack) begin
                    d_ack   = 1'b1;
                    state_d = IDLE;
                    last_d  = PORT_D;
                end else if (timeout) begin
                    d_err   = 1'b1;
                    state_d = IDLE;
                    last_d  = PORT_D;
                end
            end
            default: state_d = IDLE;
        endcase

        // Silence the bus during the reset cycle itself, not just after it.
        if (rst) begin
            s_cyc      = 1'b0;
            s_stb      = 1'b0;
            s_we       = 1'b0;
            s_addr     = '0;
            s_data_out = '0;
            i_ack      = 1'b0;
            i_err      = 1'b0;
            d_ack      = 1'b0;
            d_err      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= PORT_D;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Directed self-checking bench for wb_dual_master_arbiter (watchdog set to 8 cycles).
module tb_wb_dual_master_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cyc, i_stb, i_we, i_ack, i_err;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_data_out, i_data_in;
    logic          d_cyc, d_stb, d_we, d_ack, d_err;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_data_out, d_data_in;
    logic          s_cyc, s_stb, s_we, s_ack;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data_out, s_data_in;
    logic          ack_auto, ack_drv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Slave model: either acks in the same cycle as the strobe, or follows ack_drv.
    assign s_ack = ack_auto ? (s_cyc & s_stb) : ack_drv;

    wb_dual_master_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_cyc     (i_cyc),
        .i_stb     (i_stb),
        .i_we      (i_we),
        .i_addr    (i_addr),
        .i_data_out(i_data_out),
        .i_data_in (i_data_in),
        .i_ack     (i_ack),
        .i_err     (i_err),
        .d_cyc     (d_cyc),
        .d_stb     (d_stb),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_data_out(d_data_out),
        .d_data_in (d_data_in),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .s_cyc     (s_cyc),
        .s_stb     (s_stb),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_data_out(s_data_out),
        .s_data_in (s_data_in),
        .s_ack     (s_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_i(input logic req, input logic [AW-1:0] addr);
        i_cyc = req; i_stb = req; i_we = 1'b0; i_addr = addr; i_data_out = '0;
    endtask

    task automatic set_d(input logic req, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        d_cyc = req; d_stb = req; d_we = req; d_addr = addr; d_data_out = data;
    endtask

    initial begin
        int iack_cnt;
        rst = 1'b1; ack_auto = 1'b0; ack_drv = 1'b0; s_data_in = '0;
        set_i(1'b1, 32'h0000_0040);
        set_d(1'b0, '0, '0);

        // Reset cycles: bus silent even with a request present
        next_cycle(); settle();
        check_eq("rst_scyc0", s_cyc, 1'b0);
        next_cycle(); settle();
        check_eq("rst_scyc1", s_cyc, 1'b0);
        check_eq("rst_iack", i_ack, 1'b0);
        next_cycle();
        rst = 1'b0;
        set_i(1'b0, '0);

        // I-only read
        next_cycle();
        set_i(1'b1, 32'h0000_0100);
        settle();
        check_eq("iread_idle", s_cyc, 1'b0);
        next_cycle(); settle();
        check_eq("iread_scyc", s_cyc, 1'b1);
        check_eq("iread_addr", s_addr, 32'h0000_0100);
        next_cycle(); settle();
        check_eq("iread_wait_ack", i_ack, 1'b0);
        next_cycle();
        ack_drv = 1'b1; s_data_in = 32'hCAFE_0001;
        settle();
        check_eq("iread_iack", i_ack, 1'b1);
        check_eq("iread_data", i_data_in, 32'hCAFE_0001);
        check_eq("iread_dbcast", d_data_in, 32'hCAFE_0001);
        check_eq("iread_dack", d_ack, 1'b0);
        next_cycle();
        ack_drv = 1'b0; set_i(1'b0, '0);
        settle();
        check_eq("iread_done", s_cyc, 1'b0);

        // Contested requests after reset alternate I, D, I, D ...
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0;
        set_i(1'b1, 32'h0000_0000);
        set_d(1'b1, 32'h0000_2000, 32'hDEAD_BEEF);
        for (int k = 0; k < 8; k++) begin
            settle();
            check_eq("rr_idle_gap", s_cyc, 1'b0);
            next_cycle();
            ack_drv = 1'b1;
            settle();
            check_eq("rr_addr", s_addr, (k % 2 == 1) ? 32'h0000_2000 : 32'h0000_0000);
            check_eq("rr_iack", i_ack, (k % 2 == 0) ? 1'b1 : 1'b0);
            check_eq("rr_dack", d_ack, (k % 2 == 1) ? 1'b1 : 1'b0);
            if (k % 2 == 1) begin
                check_eq("rr_we", s_we, 1'b1);
                check_eq("rr_wdata", s_data_out, 32'hDEAD_BEEF);
            end
            next_cycle();
            ack_drv = 1'b0;
        end

        // D-only burst of 4 writes, slave acks immediately
        set_i(1'b0, '0);
        set_d(1'b1, 32'h0000_4000, 32'h1111_0000);
        ack_auto = 1'b1;
        iack_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            settle();
            check_eq("burst_dack", d_ack, (c % 2 == 1) ? 1'b1 : 1'b0);
            if (c % 2 == 1) check_eq("burst_wdata", s_data_out, 32'h1111_0000);
            if (i_ack) iack_cnt++;
            next_cycle();
        end
        check_eq("burst_iack_cnt", iack_cnt, 0);
        set_d(1'b0, '0, '0);
        ack_auto = 1'b0;

        // Abort: I drops cyc before ack; last_grant must stay on D
        set_i(1'b1, 32'h0000_0300);
        settle();
        check_eq("abort_idle", s_cyc, 1'b0);
        next_cycle(); settle();
        check_eq("abort_granted", s_cyc, 1'b1);
        check_eq("abort_addr", s_addr, 32'h0000_0300);
        next_cycle();
        set_i(1'b0, 32'h0000_0300);
        settle();
        check_eq("abort_scyc", s_cyc, 1'b0);
        check_eq("abort_iack", i_ack, 1'b0);
        next_cycle();
        set_i(1'b1, 32'h0000_0300);
        set_d(1'b1, 32'h0000_2000, 32'hDEAD_BEEF);
        settle();
        check_eq("abort_idle2", s_cyc, 1'b0);
        next_cycle(); settle();
        check_eq("abort_regrant_addr", s_addr, 32'h0000_0300);
        check_eq("abort_regrant_we", s_we, 1'b0);
        ack_drv = 1'b1;
        settle();
        check_eq("abort_regrant_iack", i_ack, 1'b1);
        check_eq("abort_regrant_dack", d_ack, 1'b0);
        next_cycle();
        ack_drv = 1'b0;

        // Watchdog: D granted, slave never acks, I pending behind it
        set_i(1'b1, 32'h0000_0500);
        for (int c = 1; c <= 8; c++) begin
            next_cycle(); settle();
            check_eq("wd_scyc", s_cyc, 1'b1);
            check_eq("wd_addr", s_addr, 32'h0000_2000);
            check_eq("wd_derr", d_err, (c == 8) ? 1'b1 : 1'b0);
            check_eq("wd_ierr", i_err, 1'b0);
        end
        next_cycle();
        set_d(1'b0, '0, '0);
        settle();
        check_eq("wd_after_scyc", s_cyc, 1'b0);
        check_eq("wd_after_derr", d_err, 1'b0);
        next_cycle(); settle();
        check_eq("wd_i_granted", s_cyc, 1'b1);
        check_eq("wd_i_addr", s_addr, 32'h0000_0500);
        ack_drv = 1'b1;
        settle();
        check_eq("wd_i_ack", i_ack, 1'b1);
        next_cycle();
        ack_drv = 1'b0;

        // Reset mid-transfer discards the pending ack
        set_i(1'b1, 32'h0000_0600);
        next_cycle(); settle();
        check_eq("midrst_granted", s_cyc, 1'b1);
        next_cycle();
        rst = 1'b1; ack_drv = 1'b1;
        settle();
        check_eq("midrst_scyc", s_cyc, 1'b0);
        check_eq("midrst_iack", i_ack, 1'b0);
        next_cycle();
        rst = 1'b0;
        set_d(1'b1, 32'h0000_2000, 32'hDEAD_BEEF);
        settle();
        check_eq("postrst_scyc", s_cyc, 1'b0);
        check_eq("postrst_iack", i_ack, 1'b0);
        check_eq("postrst_ierr", i_err, 1'b0);
        check_eq("postrst_dack", d_ack, 1'b0);
        next_cycle();
        ack_drv = 1'b0;
        settle();
        check_eq("postrst_i_first", s_addr, 32'h0000_0600);
        check_eq("postrst_we", s_we, 1'b0);
        ack_drv = 1'b1;
        settle();
        check_eq("postrst_i_ack", i_ack, 1'b1);
        next_cycle();
        ack_drv = 1'b0;
        set_i(1'b0, '0);
        set_d(1'b0, '0, '0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_dual_master_arbiter.md
Name: wb_dual_master_arbiter

Overview:
- Shares one Wishbone-classic slave port (the Controller's core memory bus) between two core masters: instruction fetch (port I) and data load/store (port D).
- Used when the second memory bus is disabled, so a Harvard core runs against a single memory.
- Arbitration is round-robin, one transfer per grant.
- A watchdog ends any transfer the slave never acknowledges, so the core cannot hang.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- TIMEOUT_CYCLES, 1024, cycles in a granted state without s_ack before an error termination; 0 disables the watchdog.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- i_cyc, i_stb, i_we  in  1 each  instruction master request, strobe, write enable.
- i_addr  in  ADDR_WIDTH  instruction address.
- i_data_out  in  DATA_WIDTH  instruction master write data.
- i_data_in  out  DATA_WIDTH  read data to instruction master.
- i_ack, i_err  out  1 each  transfer done / error termination, instruction port.
- d_cyc, d_stb, d_we, d_addr, d_data_out, d_data_in, d_ack, d_err  same as the i_* set, for the data master.
- s_cyc, s_stb, s_we  out  1 each  slave bus request, strobe, write enable.
- s_addr  out  ADDR_WIDTH  slave address.
- s_data_out  out  DATA_WIDTH  slave write data.
- s_data_in  in  DATA_WIDTH  slave read data.
- s_ack  in  1  slave acknowledge.

Behaviour:
- FSM states: IDLE, GRANT_I, GRANT_D, with a registered state. A 1-bit last_grant register holds the last port served (0 = I, 1 = D).
- Reset: state = IDLE, last_grant = 1 (I wins the first tie), watchdog = 0. All s_* outputs are 0 and i_ack, i_err, d_ack, d_err are 0 in the reset cycle and the cycle after.
- A master requests when cyc & stb = 1.
- IDLE transitions:
  - only I requests -> GRANT_I.
  - only D requests -> GRANT_D.
  - both request -> grant the port not equal to last_grant.
  - The state change is registered: a request at cycle N reaches the slave at N+1.
- Granted state outputs:
  - s_cyc, s_stb, s_we, s_addr, s_data_out come combinationally from the granted master.
  - In IDLE all of them are driven 0.
- Return path:
  - s_data_in is broadcast to i_data_in and d_data_in.
  - s_ack is forwarded combinationally only to the granted master's ack; the other ack stays 0.
- Leaving a granted state:
  - s_ack = 1 -> IDLE next cycle and last_grant updates to the served port. There is one idle cycle between transfers, so the best-case rate is one transfer per 2 cycles plus slave latency.
  - Granted master drops cyc before ack (abort) -> IDLE next cycle. No ack is delivered and last_grant is not updated.
  - s_ack arriving in IDLE is ignored.
- Watchdog:
  - Counter clears on entering a granted state and increments each cycle without s_ack.
  - When the counter equals TIMEOUT_CYCLES-1 and s_ack = 0, the granted master's err pulses for 1 cycle, s_cyc drops, the FSM returns to IDLE and last_grant updates.
  - If s_ack and the timeout coincide, ack wins and err stays 0.
  - Counter width is $clog2(TIMEOUT_CYCLES+1), saturating.
- Reset asserted mid-transfer: IDLE on the next edge, s_cyc = 0 that cycle, and any pending ack is discarded.
- Masters hold their request signals stable until ack or err (Wishbone classic); the arbiter does not register master inputs.

Decomposition:
- Package wb_arb_pkg: enum arb_state_e {IDLE, GRANT_I, GRANT_D}, localparam PORT_I = 0, localparam PORT_D = 1.
- One sub-module, wb_arb_watchdog: counter, clear/enable inputs, timeout pulse output, bypassed when TIMEOUT_CYCLES = 0.

Test Plan:
- I-only read: i_cyc = i_stb = 1, addr 0x100; slave acks 2 cycles after s_cyc -> s_addr = 0x100 from cycle N+1; i_ack = 1 at N+3 with i_data_in = slave data; d_ack stays 0.
- Simultaneous requests after reset (I addr 0x0, D write addr 0x2000, data 0xDEADBEEF, both held) -> I served first, then D; the D transfer shows s_we = 1 and s_data_out = 0xDEADBEEF. Three more back-to-back rounds alternate I, D, I, D.
- D-only burst of 4 writes with an immediate slave ack -> 4 d_ack pulses spaced 2 cycles apart; no i_ack pulses.
- Abort: I granted, i_cyc dropped before ack -> s_cyc = 0 next cycle; a following contested request goes to I again, because last_grant was not updated.
- Timeout with TIMEOUT_CYCLES = 8 and a slave that never acks -> d_err pulses exactly 8 cycles after the grant; s_cyc = 0 the next cycle; a pending I request is granted after one IDLE cycle.
- Reset pulsed mid-transfer while granted -> next cycle state IDLE, s_cyc = 0, no ack or err; a new I request is granted first.
